// File: rtl/ysyx_25040129_ifu_if.sv
// IFU bundle: AXI4-Lite-style read channel toward memory plus the
// valid/ready handoff of {pc, inst, fault} toward the IDU.
interface ysyx_25040129_ifu_if;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic [31:0] pc_out_ifu;
  logic [31:0] inst_out_ifu;
  logic        inst_fault_out_ifu;
  logic        is_req_valid_to_idu;
  logic        is_req_ready_from_idu;

  modport master (
    output mem_arvalid,
    output mem_araddr,
    input  mem_arready,
    input  mem_rvalid,
    input  mem_rdata,
    input  mem_rresp,
    output mem_rready,
    output pc_out_ifu,
    output inst_out_ifu,
    output inst_fault_out_ifu,
    output is_req_valid_to_idu,
    input  is_req_ready_from_idu
  );

  modport slave (
    input  mem_arvalid,
    input  mem_araddr,
    output mem_arready,
    output mem_rvalid,
    output mem_rdata,
    output mem_rresp,
    input  mem_rready,
    input  pc_out_ifu,
    input  inst_out_ifu,
    input  inst_fault_out_ifu,
    input  is_req_valid_to_idu,
    output is_req_ready_from_idu
  );
endinterface

// File: rtl/ysyx_25040129_ifu.sv
// Instruction fetch unit: one outstanding read, redirect drops wrong path.
// Ports: clk, rst_n, bus (master modport), redirect_valid, redirect_pc.
module ysyx_25040129_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ysyx_25040129_ifu_if.master        bus,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_q, pend_d;
  logic        drop_q, drop_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;
  logic [31:0] rpc;

  assign rpc = redirect_pc & ~32'h3;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    fault_d    = fault_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) fetch_pc_d = rpc;
      end
      REQ: begin
        // Address must stay put until accepted; remember the target.
        if (redirect_valid) begin
          drop_d = 1'b1;
          pend_d = rpc;
        end
        if (bus.mem_arready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          if (redirect_valid || drop_q) begin
            drop_d     = 1'b0;
            fetch_pc_d = redirect_valid ? rpc : pend_q;
            state_d    = REQ;
          end else begin
            pc_d    = fetch_pc_q;
            inst_d  = bus.mem_rdata;
            fault_d = (bus.mem_rresp != 2'b00);
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
          pend_d = rpc;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          fetch_pc_d = rpc;
          state_d    = REQ;
        end else if (bus.is_req_ready_from_idu) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    arvalid_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_q     <= 32'h0;
      drop_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      pc_q       <= RESET_PC;
      inst_q     <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      arvalid_q  <= arvalid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.mem_arvalid         = arvalid_q;
  assign bus.mem_araddr          = fetch_pc_q;
  assign bus.mem_rready          = (state_q == WAIT);
  assign bus.pc_out_ifu          = pc_q;
  assign bus.inst_out_ifu        = inst_q;
  assign bus.inst_fault_out_ifu  = fault_q;
  assign bus.is_req_valid_to_idu = (state_q == HOLD) && !redirect_valid;

endmodule

// File: tb/tb_ysyx_25040129_ifu.sv
// Directed cycle-by-cycle bench for the IFU.
// Inputs are driven at negedge, outputs compared 1ns later.
module tb_ysyx_25040129_ifu;

  localparam logic [31:0] A = 32'h3000_0000;
  localparam logic [31:0] R = 32'h8000_0000;

  typedef struct {
    logic        ar;
    logic        rv;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        rdy;
    logic        rdr;
    logic [31:0] rpc;
    logic        e_arv;
    logic [31:0] e_addr;
    logic        e_rr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_flt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  int          checks;
  int          errors;
  vec_t        tbl[$];

  ysyx_25040129_ifu_if bus ();

  ysyx_25040129_ifu #(
    .RESET_PC(A)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.master),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic ar, input logic rv,
    input logic [31:0] rd, input logic [1:0] rs,
    input logic rdy, input logic rdr,
    input logic [31:0] rpc,
    input logic e_arv, input logic [31:0] e_addr,
    input logic e_rr, input logic e_v,
    input logic [31:0] e_pc, input logic [31:0] e_inst,
    input logic e_flt);
    vec_t v;
    v.ar = ar; v.rv = rv; v.rd = rd; v.rs = rs;
    v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
    v.e_arv = e_arv; v.e_addr = e_addr; v.e_rr = e_rr;
    v.e_v = e_v; v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_flt = e_flt;
    return v;
  endfunction

  // Shorthands: ar = REQ cycle, rsp = WAIT cycle, hd = HOLD cycle.
  function automatic vec_t ar(input logic a, input logic [31:0] addr);
    return mk(a, 0, 0, 0, 1, 0, 0, 1, addr, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t rsp(input logic rv, input logic [31:0] rd,
                               input logic [1:0] rs);
    return mk(0, rv, rd, rs, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  endfunction

  function automatic vec_t hd(input logic rdy, input logic [31:0] pc,
                              input logic [31:0] inst, input logic f);
    return mk(0, 0, 0, 0, rdy, 0, 0, 0, 0, 0, 1, pc, inst, f);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    bus.mem_arready           = v.ar;
    bus.mem_rvalid            = v.rv;
    bus.mem_rdata             = v.rd;
    bus.mem_rresp             = v.rs;
    bus.is_req_ready_from_idu = v.rdy;
    redirect_valid            = v.rdr;
    redirect_pc               = v.rpc;
    #1;
    chk({tag, " arvalid"}, {31'b0, bus.mem_arvalid}, {31'b0, v.e_arv});
    if (v.e_arv)
      chk({tag, " araddr"}, bus.mem_araddr, v.e_addr);
    chk({tag, " rready"}, {31'b0, bus.mem_rready}, {31'b0, v.e_rr});
    chk({tag, " valid"}, {31'b0, bus.is_req_valid_to_idu},
        {31'b0, v.e_v});
    if (v.e_v) begin
      chk({tag, " pc"}, bus.pc_out_ifu, v.e_pc);
      chk({tag, " inst"}, bus.inst_out_ifu, v.e_inst);
      chk({tag, " fault"}, {31'b0, bus.inst_fault_out_ifu},
          {31'b0, v.e_flt});
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " arvalid"}, {31'b0, bus.mem_arvalid}, 32'h0);
    chk({tag, " rready"}, {31'b0, bus.mem_rready}, 32'h0);
    chk({tag, " araddr"}, bus.mem_araddr, A);
    chk({tag, " valid"}, {31'b0, bus.is_req_valid_to_idu}, 32'h0);
    chk({tag, " pc"}, bus.pc_out_ifu, A);
    chk({tag, " inst"}, bus.inst_out_ifu, 32'h0);
    chk({tag, " fault"}, {31'b0, bus.inst_fault_out_ifu}, 32'h0);
  endtask

  task automatic idle_inputs();
    bus.mem_arready           = 1'b0;
    bus.mem_rvalid            = 1'b0;
    bus.mem_rdata             = 32'h0;
    bus.mem_rresp             = 2'b00;
    bus.is_req_ready_from_idu = 1'b0;
    redirect_valid            = 1'b0;
    redirect_pc               = 32'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset("rst0");

    // Zero-wait fetch of three instructions (cycles 1..9).
    tbl.push_back(ar(1, A));
    tbl.push_back(rsp(1, 32'h0000_0013, 0));
    tbl.push_back(hd(1, A, 32'h0000_0013, 0));
    tbl.push_back(ar(1, A + 4));
    tbl.push_back(rsp(1, 32'h0000_0093, 0));
    tbl.push_back(hd(1, A + 4, 32'h0000_0093, 0));
    tbl.push_back(ar(1, A + 8));
    tbl.push_back(rsp(1, 32'h0000_0113, 0));
    tbl.push_back(hd(1, A + 8, 32'h0000_0113, 0));
    // IDU stalls five cycles in HOLD.
    tbl.push_back(ar(1, A + 12));
    tbl.push_back(rsp(1, 32'h0000_0193, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(hd(0, A + 12, 32'h0000_0193, 0));
    tbl.push_back(hd(1, A + 12, 32'h0000_0193, 0));
    // arready delayed 3 cycles, redirect in the second.
    tbl.push_back(ar(0, A + 16));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, R,
                     1, A + 16, 0, 0, 0, 0, 0));
    tbl.push_back(ar(0, A + 16));
    tbl.push_back(ar(1, A + 16));
    tbl.push_back(rsp(1, 32'h0000_0213, 0));
    tbl.push_back(ar(1, R));
    tbl.push_back(rsp(1, 32'h0000_0293, 0));
    tbl.push_back(hd(1, R, 32'h0000_0293, 0));
    // Two redirects during WAIT; the last target wins.
    tbl.push_back(ar(1, R + 4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, R + 32'h10,
                     0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, R + 32'h20,
                     0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(rsp(1, 32'h0000_0313, 0));
    tbl.push_back(ar(1, R + 32'h20));
    tbl.push_back(rsp(1, 32'h0000_0393, 0));
    // Redirect beats a ready IDU in HOLD; low bits cleared.
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h9000_0003,
                     0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ar(1, 32'h9000_0000));
    tbl.push_back(rsp(1, 32'h0000_0413, 0));
    tbl.push_back(hd(1, 32'h9000_0000, 32'h0000_0413, 0));
    tbl.push_back(ar(0, 32'h9000_0004));

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("v%0d", i + 1));

    // Reset in the middle of a pending address phase.
    #2 rst_n = 1'b0;
    #1 chk_reset("rst1");
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Stale rvalid after release must not be accepted.
    apply(mk(0, 1, 32'h0bad_0bad, 0, 1, 0, 0,
             1, A, 0, 0, 0, 0, 0), "h1");
    apply(ar(1, A), "h2");
    apply(rsp(1, 32'h0000_0013, 0), "h3");
    apply(hd(1, A, 32'h0000_0013, 0), "h4");
    // Fault response passes through, next fetch is clean.
    apply(ar(1, A + 4), "h5");
    apply(rsp(1, 32'hdead_beef, 2'b10), "h6");
    apply(hd(1, A + 4, 32'hdead_beef, 1), "h7");
    apply(ar(1, A + 8), "h8");
    apply(rsp(1, 32'h0000_0093, 0), "h9");
    apply(hd(1, A + 8, 32'h0000_0093, 0), "h10");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
